// File: rtl/wb_frame_mem_pkg.sv
// rtl/wb_frame_mem_pkg.sv - shared types and constants for the Wishbone frame store
package wb_frame_mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wb_frame_mem_if.sv
// rtl/wb_frame_mem_if.sv - Wishbone classic single-word bus bundle
interface wb_frame_mem_if #(
  parameter int ADR_W = 22
);
  import wb_frame_mem_pkg::*;

  logic              cyc_i;
  logic              stb_i;
  logic              we_i;
  logic [ADR_W-1:0]  adr_i;
  logic [WORD_W-1:0] dat_i;
  logic [WORD_W-1:0] dat_o;
  logic              ack_o;
  logic              err_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i,
    input  dat_o, ack_o, err_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o, err_o
  );

endinterface

// File: rtl/frame_mem_ram.sv
// rtl/frame_mem_ram.sv - single-port synchronous RAM, registered read, contents never reset
module frame_mem_ram
  import wb_frame_mem_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/wb_frame_mem.sv
// rtl/wb_frame_mem.sv - Wishbone classic frame store with programmable wait states
// Optional access counters enabled by WB_FRAME_MEM_ACCESS_COUNT_EN.
module wb_frame_mem
  import wb_frame_mem_pkg::*;
#(
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 2,
  parameter int ADR_W       = 22
) (
  input  logic                clk_i,
  input  logic                rst_i,
  wb_frame_mem_if.slave       bus
`ifdef WB_FRAME_MEM_ACCESS_COUNT_EN
  ,
  input  logic                cnt_clr_i,
  output logic [WORD_W-1:0]   rd_count_o,
  output logic [WORD_W-1:0]   wr_count_o
`endif
);

  localparam int IW     = idx_width(DEPTH);
  localparam int WIDX_W = ADR_W - 2;
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_WAIT = ST_WAIT;
  localparam logic [1:0] S_RESP = ST_RESP;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]        state;
  logic [3:0]        wait_cnt;
  logic              we_q;
  logic              err_q;
  logic [IW-1:0]     idx_q;
  logic [WORD_W-1:0] wdat_q;

  logic              req;
  logic [WIDX_W-1:0] word_idx;
  logic              in_range;
  logic              ram_we;
  logic              ram_re;
  logic [IW-1:0]     ram_addr;
  logic [WORD_W-1:0] ram_rdata;
  logic              resp_ok;
  logic              unused_adr;

  assign req        = bus.cyc_i & bus.stb_i;
  assign word_idx   = bus.adr_i[ADR_W-1:2];
  assign in_range   = 32'(word_idx) < $unsigned(DEPTH);
  assign unused_adr = ^bus.adr_i[1:0];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      wdat_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            we_q   <= bus.we_i;
            idx_q  <= word_idx[IW-1:0];
            wdat_q <= bus.dat_i;
            err_q  <= !in_range;
            if (!in_range || WAIT_CYCLES == 0) begin
              state <= S_RESP;
            end else begin
              wait_cnt <= WAIT_LOAD;
              state    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // master withdrew the request: drop it silently
          if (!req)                 state <= S_IDLE;
          else if (wait_cnt == 4'd0) state <= S_RESP;
          else                      wait_cnt <= wait_cnt - 4'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read is launched one cycle ahead so the registered RAM output lines up with RESP.
  assign ram_re = (state == S_IDLE && req && !bus.we_i && in_range && WAIT_CYCLES == 0) ||
                  (state == S_WAIT && req && !we_q && wait_cnt == 4'd0);
  assign ram_we   = rst_i && state == S_RESP && we_q && !err_q;
  assign ram_addr = (state == S_IDLE) ? word_idx[IW-1:0] : idx_q;

  frame_mem_ram #(
    .DEPTH (DEPTH),
    .AW    (IW)
  ) u_ram (
    .clk_i (clk_i),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (wdat_q),
    .rdata (ram_rdata)
  );

  assign resp_ok   = (state == S_RESP) && !err_q;
  assign bus.ack_o = resp_ok;
  assign bus.err_o = (state == S_RESP) && err_q;
  assign bus.dat_o = (resp_ok && !we_q) ? ram_rdata : '0;

`ifdef WB_FRAME_MEM_ACCESS_COUNT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i || cnt_clr_i) begin
      rd_count_o <= '0;
      wr_count_o <= '0;
    end else if (resp_ok) begin
      if (!we_q && rd_count_o != 32'hFFFF_FFFF) rd_count_o <= rd_count_o + 32'd1;
      if (we_q && wr_count_o != 32'hFFFF_FFFF)  wr_count_o <= wr_count_o + 32'd1;
    end
  end
`endif

endmodule
